// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi_lite_pkg
// Brief    : Shared AXI-Lite response codes, regfile FSM state types and the
//            byte-strobe merge helper used by the bridge and its slaves.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] v;
        v = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                v[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
// Interface : axi_lite_if
// Brief     : AXI-Lite bundle (AW/W/B/AR/R) with the clock and active-low
//             reset carried alongside, plus master and slave modports.
// Revision  : 1.0 - initial release
// ============================================================================
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst_n
);

    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport slave (
        input  clk, rst_n,
        input  aw_addr, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );

    modport master (
        input  clk, rst_n,
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile
// Brief    : AXI-Lite slave register file. NUM_REGS 32-bit registers, each
//            either RW (drives reg_q) or RO (reads hw_in). AW and W accepted
//            in either order; OKAY or SLVERR responses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                             ADDR_WIDTH = 32,
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 8,
    parameter int                             WINDOW_W   = 12,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    axi_lite_if.slave                             s_axi,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                   reg_wr_pulse,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   hw_in
);

    import axi_lite_pkg::*;

    localparam int c_idx_w  = WINDOW_W - 2;
    localparam int c_strb_w = DATA_WIDTH / 8;

    wr_state_e               r_wr_state;
    wr_state_e               w_wr_state_nxt;
    rd_state_e               r_rd_state;
    rd_state_e               w_rd_state_nxt;

    logic [c_idx_w-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [c_strb_w-1:0]     r_w_strb;
    logic [1:0]              r_b_resp;
    logic [DATA_WIDTH-1:0]   r_r_data;
    logic [1:0]              r_r_resp;
    logic [NUM_REGS-1:0]     r_wr_pulse;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_commit;
    logic [c_idx_w-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0]   w_cm_data;
    logic [c_strb_w-1:0]     w_cm_strb;
    logic [NUM_REGS-1:0]     w_wr_sel;
    logic                    w_wr_ok;
    logic [c_idx_w-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_rd_ok;
    logic                    w_unused;

    // Readies and valids come from state alone, never from the incoming valids.
    assign s_axi.aw_ready = (r_wr_state == W_IDLE) || (r_wr_state == W_GOT_W);
    assign s_axi.w_ready  = (r_wr_state == W_IDLE) || (r_wr_state == W_GOT_AW);
    assign s_axi.b_valid  = (r_wr_state == W_RESP);
    assign s_axi.b_resp   = r_b_resp;
    assign s_axi.ar_ready = (r_rd_state == R_IDLE);
    assign s_axi.r_valid  = (r_rd_state == R_RESP);
    assign s_axi.r_data   = r_r_data;
    assign s_axi.r_resp   = r_r_resp;
    assign reg_wr_pulse   = r_wr_pulse;

    assign w_aw_hs = s_axi.aw_valid && s_axi.aw_ready;
    assign w_w_hs  = s_axi.w_valid  && s_axi.w_ready;
    assign w_b_hs  = s_axi.b_valid  && s_axi.b_ready;
    assign w_ar_hs = s_axi.ar_valid && s_axi.ar_ready;
    assign w_r_hs  = s_axi.r_valid  && s_axi.r_ready;

    // Whichever half arrived first was latched; the other comes straight off the bus.
    assign w_wr_idx  = (r_wr_state == W_GOT_AW) ? r_aw_idx : s_axi.aw_addr[WINDOW_W-1:2];
    assign w_cm_data = (r_wr_state == W_GOT_W)  ? r_w_data : s_axi.w_data;
    assign w_cm_strb = (r_wr_state == W_GOT_W)  ? r_w_strb : s_axi.w_strb;
    assign w_rd_idx  = s_axi.ar_addr[WINDOW_W-1:2];

    // Address bits outside the decoded index are ignored by design.
    assign w_unused = ^{s_axi.aw_addr[ADDR_WIDTH-1:WINDOW_W], s_axi.aw_addr[1:0],
                        s_axi.ar_addr[ADDR_WIDTH-1:WINDOW_W], s_axi.ar_addr[1:0], hw_in};

    // Write FSM next state; commit fires on the edge completing the second of AW/W.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_commit       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_wr_state_nxt = W_GOT_AW;
                end else if (w_w_hs) begin
                    w_wr_state_nxt = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_w_hs) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_GOT_W: begin
                if (w_aw_hs) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write decode: only an in-range RW index is selected; anything else is an error.
    always_comb begin
        w_wr_sel = '0;
        w_wr_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((w_wr_idx == c_idx_w'(i)) && !RO_MASK[i]) begin
                w_wr_sel[i] = w_commit;
                w_wr_ok     = 1'b1;
            end
        end
    end

    // Write FSM state, half-transaction captures, response and pulse.
    always_ff @(posedge s_axi.clk or negedge s_axi.rst_n) begin
        if (!s_axi.rst_n) begin
            r_wr_state <= W_IDLE;
            r_aw_idx   <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_resp   <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_pulse <= w_wr_sel;
            if ((r_wr_state == W_IDLE) && w_aw_hs) begin
                r_aw_idx <= s_axi.aw_addr[WINDOW_W-1:2];
            end
            if ((r_wr_state == W_IDLE) && w_w_hs) begin
                r_w_data <= s_axi.w_data;
                r_w_strb <= s_axi.w_strb;
            end
            if (w_commit) begin
                r_b_resp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register storage: RO slots hold nothing and present zero on reg_q.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            if (RO_MASK[i]) begin : g_ro
                assign reg_q[i] = '0;
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] r_val;
                // Byte-lane update on an accepted write; zero strobe keeps the value.
                always_ff @(posedge s_axi.clk or negedge s_axi.rst_n) begin
                    if (!s_axi.rst_n) begin
                        r_val <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
                    end else if (w_wr_sel[i]) begin
                        r_val <= strb_merge(r_val, w_cm_data, w_cm_strb);
                    end
                end
                assign reg_q[i] = r_val;
            end
        end
    endgenerate

    // Read mux: RW returns stored value (pre-write on a same-cycle write), RO returns hw_in.
    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == c_idx_w'(i)) begin
                w_rd_ok   = 1'b1;
                w_rd_data = RO_MASK[i] ? hw_in[i] : reg_q[i];
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_RESP;
            R_RESP:  if (w_r_hs)  w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state and response snapshot held until r_ready.
    always_ff @(posedge s_axi.clk or negedge s_axi.rst_n) begin
        if (!s_axi.rst_n) begin
            r_rd_state <= R_IDLE;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_ar_hs) begin
                r_r_data <= w_rd_ok ? w_rd_data : '0;
                r_r_resp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regfile
// Brief    : Scoreboard bench for axi_lite_regfile: driver pushes expected
//            B/R responses from a register-array model, monitor pops/compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    import axi_lite_pkg::*;

    localparam int            NR = 8;
    localparam logic [NR-1:0] RO = 8'b0100_1000;
    localparam logic [NR*32-1:0] RV = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005,
                                       32'h0000_0000, 32'h3333_0003, 32'hAAAA_AAAA,
                                       32'h1111_0001, 32'hC0DE_0000};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus (.clk(clk), .rst_n(rst_n));

    logic [NR-1:0][31:0] reg_q;
    logic [NR-1:0][31:0] hw_in;
    logic [NR-1:0]       reg_wr_pulse;

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .WINDOW_W(12),
        .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .s_axi(bus), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .hw_in(hw_in)
    );

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [NR];
    int          exp_pulses [NR];
    int          seen_pulses [NR];
    logic [1:0]  b_q [$];
    rexp_t       r_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: handshake did not occur within budget at %0t", name, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = RV[i*32 +: 32];
    endtask

    // Reference behaviour: register array indexed by addr[11:2].
    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int i;
        i = int'(addr[11:2]);
        if (i < NR) begin
            if (!RO[i]) begin
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[i][8*k +: 8] = data[8*k +: 8];
                exp_pulses[i]++;
                b_q.push_back(RESP_OKAY);
            end else begin
                b_q.push_back(RESP_SLVERR);
            end
        end else begin
            b_q.push_back(RESP_SLVERR);
        end
    endtask

    task automatic exp_read(input logic [31:0] addr);
        int    i;
        rexp_t e;
        i = int'(addr[11:2]);
        if (i >= NR)      e = '{data: 32'h0,   resp: RESP_SLVERR};
        else if (RO[i])   e = '{data: hw_in[i], resp: RESP_OKAY};
        else              e = '{data: model[i], resp: RESP_OKAY};
        r_q.push_back(e);
    endtask

    task automatic aw_phase(input logic [31:0] a);
        int n = 0;
        bus.aw_addr = a; bus.aw_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.aw_ready) break;
            if (++n > 50) begin timeout("aw_handshake"); break; end
        end
        @(posedge clk); #1; bus.aw_valid = 1'b0;
    endtask

    task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.w_data = d; bus.w_strb = s; bus.w_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.w_ready) break;
            if (++n > 50) begin timeout("w_handshake"); break; end
        end
        @(posedge clk); #1; bus.w_valid = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] a);
        int n = 0;
        bus.ar_addr = a; bus.ar_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.ar_ready) break;
            if (++n > 50) begin timeout("ar_handshake"); break; end
        end
        @(posedge clk); #1; bus.ar_valid = 1'b0;
    endtask

    task automatic b_phase(input int hold);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.b_valid) break;
            if (++n > 50) begin timeout("b_valid_wait"); break; end
        end
        repeat (hold) @(negedge clk);
        @(posedge clk); #1; bus.b_ready = 1'b1;
        @(posedge clk); #1; bus.b_ready = 1'b0;
    endtask

    task automatic r_phase(input int hold);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.r_valid) break;
            if (++n > 50) begin timeout("r_valid_wait"); break; end
        end
        repeat (hold) @(negedge clk);
        @(posedge clk); #1; bus.r_ready = 1'b1;
        @(posedge clk); #1; bus.r_ready = 1'b0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++)
            check($sformatf("reg_q[%0d]", i), reg_q[i], RO[i] ? 32'h0 : model[i]);
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap cycles between them.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input int hold);
        exp_write(addr, data, strb);
        if (order == 0) begin
            fork aw_phase(addr); w_phase(data, strb); join
        end else if (order == 1) begin
            aw_phase(addr);
            repeat (gap) begin
                @(negedge clk);
                check("aw_ready_low_got_aw", bus.aw_ready, 0);
                check("b_valid_low_got_aw", bus.b_valid, 0);
            end
            @(posedge clk); #1;
            w_phase(data, strb);
        end else begin
            w_phase(data, strb);
            repeat (gap) begin
                @(negedge clk);
                check("w_ready_low_got_w", bus.w_ready, 0);
                check("b_valid_low_got_w", bus.b_valid, 0);
            end
            @(posedge clk); #1;
            aw_phase(addr);
        end
        b_phase(hold);
        check_regs();
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        exp_read(addr);
        ar_phase(addr);
        r_phase(hold);
    endtask

    task automatic check_reset_state();
        check("rst_aw_ready", bus.aw_ready, 1);
        check("rst_w_ready",  bus.w_ready,  1);
        check("rst_ar_ready", bus.ar_ready, 1);
        check("rst_b_valid",  bus.b_valid,  0);
        check("rst_r_valid",  bus.r_valid,  0);
        check("rst_b_resp",   bus.b_resp,   0);
        check("rst_r_resp",   bus.r_resp,   0);
        check("rst_r_data",   bus.r_data,   0);
        check("rst_pulse",    reg_wr_pulse, 0);
        for (int i = 0; i < NR; i++)
            check($sformatf("rst_reg_q[%0d]", i), reg_q[i], RO[i] ? 32'h0 : RV[i*32 +: 32]);
    endtask

    // Monitor: pops expected responses at handshakes, checks hold/stability and pulses.
    logic          prev_bv, prev_brdy, prev_rv, prev_rrdy;
    logic [1:0]    prev_bresp, prev_rresp;
    logic [31:0]   prev_rdata;
    logic [NR-1:0] prev_pulse;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bv <= 1'b0; prev_rv <= 1'b0; prev_pulse <= '0;
            prev_brdy <= 1'b0; prev_rrdy <= 1'b0;
        end else begin
            if (prev_bv && !prev_brdy) begin
                check("b_valid_hold", bus.b_valid, 1);
                check("b_resp_hold",  bus.b_resp,  prev_bresp);
            end
            if (prev_rv && !prev_rrdy) begin
                check("r_valid_hold", bus.r_valid, 1);
                check("r_data_hold",  bus.r_data,  prev_rdata);
                check("r_resp_hold",  bus.r_resp,  prev_rresp);
            end
            if (bus.b_valid) begin
                check("aw_ready_during_b", bus.aw_ready, 0);
                check("w_ready_during_b",  bus.w_ready,  0);
            end
            if (bus.r_valid) check("ar_ready_during_r", bus.ar_ready, 0);
            if (bus.b_valid && bus.b_ready) begin
                if (b_q.size() == 0) timeout("b_unexpected");
                else check("b_resp", bus.b_resp, b_q.pop_front());
            end
            if (bus.r_valid && bus.r_ready) begin
                if (r_q.size() == 0) timeout("r_unexpected");
                else begin
                    rexp_t e;
                    e = r_q.pop_front();
                    check("r_data", bus.r_data, e.data);
                    check("r_resp", bus.r_resp, e.resp);
                end
            end
            check("pulse_single_cycle", prev_pulse & reg_wr_pulse, 0);
            for (int i = 0; i < NR; i++) seen_pulses[i] += reg_wr_pulse[i];
            prev_bv <= bus.b_valid; prev_brdy <= bus.b_ready; prev_bresp <= bus.b_resp;
            prev_rv <= bus.r_valid; prev_rrdy <= bus.r_ready;
            prev_rdata <= bus.r_data; prev_rresp <= bus.r_resp;
            prev_pulse <= reg_wr_pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.aw_addr = '0; bus.aw_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0;
        bus.w_valid = 1'b0; bus.b_ready = 1'b0; bus.ar_addr = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            hw_in[i] = $urandom; exp_pulses[i] = 0; seen_pulses[i] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state();
        @(posedge clk); #1; rst_n = 1'b1;

        // Aligned write with latency and pulse-shape checks, then read back.
        exp_write(32'h004, 32'hDEAD_BEEF, 4'hF);
        fork aw_phase(32'h004); w_phase(32'hDEAD_BEEF, 4'hF); join
        @(negedge clk);
        check("b_valid_latency", bus.b_valid, 1);
        check("pulse_reg1", reg_wr_pulse, 8'h02);
        check("reg1_value", reg_q[1], 32'hDEAD_BEEF);
        @(negedge clk);
        check("pulse_reg1_gone", reg_wr_pulse, 8'h00);
        b_phase(0);
        do_read(32'h004, 0);

        // W three cycles ahead of AW, partial strobe over 0xAAAAAAAA.
        do_write(32'h008, 32'h1122_3344, 4'h5, 2, 3, 0);
        check("strobe_merge_reg2", reg_q[2], 32'hAA22_AA44);
        do_write(32'h014, 32'h0BAD_F00D, 4'hC, 1, 2, 0);
        do_write(32'h01C, 32'h1234_5678, 4'h0, 0, 0, 0);

        // Error responses.
        do_write(32'h00C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(32'h020, 32'hFFFF_FFFF, 4'hF, 1, 1, 0);
        hw_in[3] = 32'h5A5A_0001;
        do_read(32'h00C, 0);
        do_read(32'h400, 0);

        // Backpressure on both response channels at once.
        fork
            do_write(32'h000, 32'hCAFE_0123, 4'hF, 0, 0, 5);
            do_read(32'h014, 5);
        join

        // Same-cycle write and read of reg 4 (currently 0): read sees the old value.
        exp_read(32'h010);
        exp_write(32'h010, 32'h0000_0001, 4'hF);
        fork aw_phase(32'h010); w_phase(32'h0000_0001, 4'hF); ar_phase(32'h010); join
        fork b_phase(0); r_phase(0); join
        do_read(32'h010, 0);

        // Randomized traffic; upper address bits and byte offset are noise.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a;
            hw_in[$urandom_range(0, NR-1)] = $urandom;
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end
        check_regs();

        // Reset with AW accepted but no W: capture must be discarded.
        aw_phase(32'h014);
        @(negedge clk);
        check("aw_ready_low_before_rst", bus.aw_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clk); #1; rst_n = 1'b1;
        w_phase(32'hFFFF_FFFF, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check("no_commit_after_rst_b_valid", bus.b_valid, 0);
        end
        check_regs();
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        do_read(32'h014, 0);
        repeat (3) @(negedge clk);

        check("b_queue_drained", b_q.size(), 0);
        check("r_queue_drained", r_q.size(), 0);
        for (int i = 0; i < NR; i++)
            check($sformatf("pulse_count[%0d]", i), seen_pulses[i], exp_pulses[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
